// File: rtl/sa_accept_if.sv
// Purpose: move / exp-unit / decision signal bundle for sa_accept_decider.
// Latency: none (wires only); the master side offers moves and returns exp results.
// Backpressure: move_valid/move_ready handshake; exp side is a start pulse plus a level valid.
interface sa_accept_if;
    logic        move_valid;
    logic        move_ready;
    logic        move_improves;
    logic [31:0] move_arg;
    logic [31:0] exp_inp;
    logic        exp_inp_valid;
    logic [31:0] exp_res;
    logic        exp_res_valid;
    logic        dec_valid;
    logic        dec_accept;
    logic        dec_timeout;
`ifdef SA_ACCEPT_STATS_EN
    logic [15:0] accept_cnt;
    logic [15:0] reject_cnt;
`endif

    // Upstream move source together with the exp unit's result side.
    modport master (
        output move_valid, move_improves, move_arg, exp_res, exp_res_valid,
        input  move_ready, exp_inp, exp_inp_valid, dec_valid, dec_accept, dec_timeout
`ifdef SA_ACCEPT_STATS_EN
        , input accept_cnt, reject_cnt
`endif
    );

    // The acceptance decider itself.
    modport slave (
        input  move_valid, move_improves, move_arg, exp_res, exp_res_valid,
        output move_ready, exp_inp, exp_inp_valid, dec_valid, dec_accept, dec_timeout
`ifdef SA_ACCEPT_STATS_EN
        , output accept_cnt, reject_cnt
`endif
    );
endinterface

// File: rtl/sa_accept_decider.sv
// Purpose: Metropolis accept/reject for annealing moves; worsening moves query the exp unit
//          and compare its probability to a free-running 24-bit LFSR sample. Optional stats: SA_ACCEPT_STATS_EN.
// Latency: improving move decides in T+1; worsening move decides 2 cycles after the exp result
//          (or after EXP_TIMEOUT wait cycles). Backpressure: move_ready only in IDLE, one move in flight.
module sa_accept_decider #(
    parameter logic [31:0] SEED        = 32'hACE12468,
    parameter int          EXP_TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst,
    sa_accept_if.slave  bus
);

    // A zero seed would lock the LFSR at zero forever.
    localparam logic [31:0] SEED_EFF = (SEED == 32'h0) ? 32'h00000001 : SEED;
    localparam logic [7:0]  TO_LAST  = 8'(EXP_TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE, ISSUE, WAIT_LOW, WAIT_HIGH, COMPARE, DONE
    } state_t;

    state_t      state;
    logic [31:0] lfsr;
    logic [31:0] res_q;
    logic [7:0]  wait_cnt;

    logic [31:0] lfsr_nxt;
    logic [7:0]  res_exp;
    logic [22:0] res_mant;
    logic [7:0]  shamt;
    logic [23:0] p_fix;
    logic        p_one;
    logic        cmp_accept;

    assign bus.move_ready = (state == IDLE) & ~rst;

    // Galois step of the 32-bit LFSR.
    assign lfsr_nxt = lfsr[0] ? ((lfsr >> 1) ^ 32'h80200003) : (lfsr >> 1);

    assign res_exp  = res_q[30:23];
    assign res_mant = res_q[22:0];
    assign shamt    = 8'd126 - res_exp;

    // Convert the latched float probability to Q0.24 (or a sure-accept flag).
    always_comb begin
        p_fix = 24'h0;
        p_one = 1'b0;
        if (res_q[31] || (res_exp == 8'd0)) begin
            p_fix = 24'h0;
        end else if ((res_exp == 8'd255) && (res_mant != 23'h0)) begin
            p_fix = 24'h0;
        end else if (res_exp >= 8'd127) begin
            p_one = 1'b1;
        end else if (shamt < 8'd24) begin
            p_fix = {1'b1, res_mant} >> shamt[4:0];
        end
    end

    assign cmp_accept = p_one | (lfsr[23:0] < p_fix);

    // Control FSM, LFSR and all registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state             <= IDLE;
            lfsr              <= SEED_EFF;
            res_q             <= 32'h0;
            wait_cnt          <= 8'h0;
            bus.exp_inp       <= 32'h0;
            bus.exp_inp_valid <= 1'b0;
            bus.dec_valid     <= 1'b0;
            bus.dec_accept    <= 1'b0;
            bus.dec_timeout   <= 1'b0;
        end else begin
            lfsr              <= lfsr_nxt;
            bus.exp_inp_valid <= 1'b0;
            bus.dec_valid     <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.move_valid) begin
                        if (bus.move_improves) begin
                            bus.dec_valid   <= 1'b1;
                            bus.dec_accept  <= 1'b1;
                            bus.dec_timeout <= 1'b0;
                            state           <= DONE;
                        end else begin
                            bus.exp_inp       <= bus.move_arg;
                            bus.exp_inp_valid <= 1'b1;
                            state             <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    wait_cnt <= 8'h0;
                    state    <= WAIT_LOW;
                end
                WAIT_LOW, WAIT_HIGH: begin
                    // Timeout takes priority over a result arriving in the same cycle.
                    if (wait_cnt == TO_LAST) begin
                        bus.dec_valid   <= 1'b1;
                        bus.dec_accept  <= 1'b0;
                        bus.dec_timeout <= 1'b1;
                        state           <= DONE;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                        // The idle-high valid level is stale; a fresh result needs a low first.
                        if ((state == WAIT_LOW) && !bus.exp_res_valid) begin
                            state <= WAIT_HIGH;
                        end else if ((state == WAIT_HIGH) && bus.exp_res_valid) begin
                            res_q <= bus.exp_res;
                            state <= COMPARE;
                        end
                    end
                end
                COMPARE: begin
                    bus.dec_valid   <= 1'b1;
                    bus.dec_accept  <= cmp_accept;
                    bus.dec_timeout <= 1'b0;
                    state           <= DONE;
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef SA_ACCEPT_STATS_EN
    // Saturating decision statistics; timeouts land in the reject count.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.accept_cnt <= 16'h0;
            bus.reject_cnt <= 16'h0;
        end else if (bus.dec_valid) begin
            if (bus.dec_accept) begin
                if (bus.accept_cnt != 16'hFFFF) bus.accept_cnt <= bus.accept_cnt + 16'd1;
            end else begin
                if (bus.reject_cnt != 16'hFFFF) bus.reject_cnt <= bus.reject_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_sa_accept_decider.sv
// Purpose: self-checking bench for sa_accept_decider against a float/probability reference model.
// Latency: checks exact decision timing for improving, worsening and timed-out moves.
// Backpressure: moves offered only when move_ready; exp unit modelled as a level valid.
module tb_sa_accept_decider;

    localparam logic [31:0] SEED = 32'hACE12468;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sa_accept_if bus ();

    sa_accept_decider #(.SEED(SEED), .EXP_TIMEOUT(64)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;
    int n_acc = 0;
    int m_acc = 0;
    int m_rej = 0;

    // Reference LFSR: reloaded on reset, otherwise one Galois step per clock.
    logic [31:0] m_lfsr, m_prev;
    always @(posedge clk) begin
        m_prev <= m_lfsr;
        if (rst) m_lfsr <= SEED;
        else     m_lfsr <= m_lfsr[0] ? ((m_lfsr >> 1) ^ 32'h80200003) : (m_lfsr >> 1);
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Probability from the float value: floor(p * 2^24), with p >= 1 a sure accept.
    function automatic bit ref_accept(input logic [31:0] f, input logic [23:0] r);
        int     e;
        longint m;
        longint scaled;
        int     sh;
        e = int'(f[30:23]);
        m = longint'(f[22:0]);
        if (f[31] || e == 0) return 1'b0;
        if (e == 255 && m != 0) return 1'b0;
        if (e >= 127) return 1'b1;
        // value * 2^24 = (2^23 + m) * 2^(e - 126)
        sh = 126 - e;
        if (sh >= 40) scaled = 0;
        else          scaled = (m + 64'd8388608) / (longint'(1) << sh);
        return longint'(r) < scaled;
    endfunction

    task automatic stats_check();
`ifdef SA_ACCEPT_STATS_EN
        check("accept_cnt", {16'h0, bus.accept_cnt}, m_acc);
        check("reject_cnt", {16'h0, bus.reject_cnt}, m_rej);
`endif
    endtask

    // One complete move. hang keeps exp_res_valid high so the decider must time out.
    task automatic run_move(input bit imp, input logic [31:0] arg, input logic [31:0] res,
                            input int low_cyc, input bit hang);
        int k;
        bit exp_acc;
        bit exp_to;
        check("ready_in_idle", bus.move_ready, 1);
        bus.move_valid    = 1'b1;
        bus.move_improves = imp;
        bus.move_arg      = arg;
        @(negedge clk);
        bus.move_improves = 1'($urandom);
        bus.move_arg      = $urandom;
        if (imp) begin
            bus.move_valid = 1'b0;
            check("imp_no_exp_start", bus.exp_inp_valid, 0);
            exp_acc = 1'b1;
            exp_to  = 1'b0;
        end else begin
            // Junk on move_valid while busy must be ignored.
            bus.move_valid = 1'($urandom);
            check("issue_pulse", bus.exp_inp_valid, 1);
            check("issue_arg", bus.exp_inp, arg);
            check("busy_not_ready", bus.move_ready, 0);
            if (hang) begin
                k = 0;
                while (!bus.dec_valid && k < 100) begin
                    @(negedge clk);
                    k++;
                end
                check("timeout_latency", k, 65);
                exp_acc = 1'b0;
                exp_to  = 1'b1;
            end else begin
                bus.exp_res_valid = 1'b0;
                bus.exp_res       = $urandom;
                @(negedge clk);
                check("issue_one_cycle", bus.exp_inp_valid, 0);
                repeat (low_cyc - 1) @(negedge clk);
                bus.exp_res_valid = 1'b1;
                bus.exp_res       = res;
                k = 0;
                while (!bus.dec_valid && k < 20) begin
                    @(negedge clk);
                    k++;
                end
                check("result_latency", k, 2);
                exp_acc = ref_accept(res, m_prev[23:0]);
                exp_to  = 1'b0;
            end
            bus.move_valid = 1'b0;
        end
        check("dec_valid", bus.dec_valid, 1);
        check("dec_accept", bus.dec_accept, exp_acc);
        check("dec_timeout", bus.dec_timeout, exp_to);
        n_acc += int'(bus.dec_accept);
        if (exp_acc) m_acc++;
        else         m_rej++;
        @(negedge clk);
        check("dec_one_cycle", bus.dec_valid, 0);
        check("ready_after_dec", bus.move_ready, 1);
        stats_check();
    endtask

    initial begin
        logic [31:0] res;
        rst               = 1'b1;
        bus.move_valid    = 1'b0;
        bus.move_improves = 1'b0;
        bus.move_arg      = 32'h0;
        bus.exp_res       = 32'h0;
        bus.exp_res_valid = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_ready_low", bus.move_ready, 0);
        check("rst_dec_valid", bus.dec_valid, 0);
        check("rst_dec_accept", bus.dec_accept, 0);
        check("rst_dec_timeout", bus.dec_timeout, 0);
        check("rst_exp_inp", bus.exp_inp, 0);
        check("rst_exp_inp_valid", bus.exp_inp_valid, 0);
        stats_check();
        rst = 1'b0;
        @(negedge clk);

        // Improving move, then probability exactly 1.0.
        run_move(1'b1, 32'h12345678, 32'h0, 2, 1'b0);
        run_move(1'b0, 32'hBF800000, 32'h3F800000, 3, 1'b0);

        // Zero, negative and NaN probabilities always reject.
        run_move(1'b0, 32'hC0000000, 32'h00000000, 2, 1'b0);
        run_move(1'b0, 32'hC0000000, 32'hBF000000, 4, 1'b0);
        run_move(1'b0, 32'hC0000000, 32'h7FC00000, 5, 1'b0);

        // p = 0.5: bit-exact against the LFSR model and roughly half accepted.
        n_acc = 0;
        for (int i = 0; i < 1000; i++) begin
            run_move(1'b0, $urandom, 32'h3F000000, $urandom_range(2, 6), 1'b0);
        end
        check("rate_half", 32'((n_acc >= 450) && (n_acc <= 550)), 1);

        // exp unit never drops its valid: forced timeout reject.
        run_move(1'b0, 32'hBE000000, 32'h0, 2, 1'b1);

        // Reset while waiting for the exp result.
        bus.move_valid    = 1'b1;
        bus.move_improves = 1'b0;
        bus.move_arg      = 32'hC1200000;
        @(negedge clk);
        bus.move_valid    = 1'b0;
        bus.exp_res_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        m_acc = 0;
        m_rej = 0;
        check("mid_rst_dec_valid", bus.dec_valid, 0);
        check("mid_rst_exp_inp", bus.exp_inp, 0);
        check("mid_rst_exp_inp_valid", bus.exp_inp_valid, 0);
        check("mid_rst_ready_low", bus.move_ready, 0);
        stats_check();
        rst               = 1'b0;
        bus.exp_res_valid = 1'b1;
        @(negedge clk);
        run_move(1'b0, 32'hC1200000, 32'h3F400000, 3, 1'b0);

        // Random mix: specials, tiny values (large shifts) and general probabilities.
        for (int i = 0; i < 200; i++) begin
            case ($urandom_range(0, 5))
                0:       res = 32'h7F800000;
                1:       res = {1'b0, 8'($urandom_range(90, 102)), 23'($urandom)};
                2:       res = {1'b1, 8'($urandom_range(100, 126)), 23'($urandom)};
                default: res = {1'b0, 8'($urandom_range(100, 128)), 23'($urandom)};
            endcase
            run_move(1'($urandom_range(0, 3) == 0), $urandom, res, $urandom_range(2, 8), 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
